// File: rtl/go_pkg.sv
// Shared types for the 9x9 Go board-state owner.
// Cell encoding, coordinates, FSM states and colour helpers.
package go_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BLACK = 2'b01,
        WHITE = 2'b10
    } cell_t;

    localparam int BOARD_N = 9;

    typedef logic [3:0] coord_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_PLACE,
        S_CAP_N,
        S_CAP_S,
        S_CAP_W,
        S_CAP_E,
        S_DONE,
        S_REJ
    } state_t;

    function automatic logic [1:0] opponent(input logic [1:0] c);
        return (c == BLACK) ? WHITE : BLACK;
    endfunction

endpackage

// File: rtl/go_capture_check.sv
// Single-stone capture test for one neighbour cell.
// An off-board coordinate (including 4-bit wrap) never captures.
module go_capture_check
    import go_pkg::*;
(
    input  logic [1:0] board [8:0][8:0],
    input  coord_t     nb_row,
    input  coord_t     nb_col,
    input  logic [1:0] mover,
    output logic       captured
);

    coord_t w_rn;
    coord_t w_rs;
    coord_t w_cw;
    coord_t w_ce;

    assign w_rn = nb_row - 4'd1;
    assign w_rs = nb_row + 4'd1;
    assign w_cw = nb_col - 4'd1;
    assign w_ce = nb_col + 4'd1;

    // Opponent stone whose every liberty point is edge or mover stone
    always_comb begin
        captured = 1'b0;
        if ((nb_row <= 4'd8) && (nb_col <= 4'd8)) begin
            if (board[nb_row][nb_col] == opponent(mover)) begin
                captured =
                    ((nb_row == 4'd0) || (board[w_rn][nb_col] == mover)) &&
                    ((nb_row == 4'd8) || (board[w_rs][nb_col] == mover)) &&
                    ((nb_col == 4'd0) || (board[nb_row][w_cw] == mover)) &&
                    ((nb_col == 4'd8) || (board[nb_row][w_ce] == mover));
            end
        end
    end

endmodule

// File: rtl/go_move_commit.sv
// Board-state owner: validates, commits and optionally captures moves.
// Build option: define GO_SINGLE_CAPTURE_EN to enable single-stone capture.
module go_move_commit
    import go_pkg::*;
#(
    parameter logic [1:0] LOCAL_COLOR = 2'b11
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       move_ready,
    input  logic [7:0] move_in,
    input  logic       pass_req,
    output logic [1:0] board [8:0][8:0],
    output logic [1:0] turn,
    output logic       my_turn,
    output logic       move_ack,
    output logic       move_rej,
    output logic       game_over,
    output logic [7:0] move_count,
    output logic [6:0] black_caps,
    output logic [6:0] white_caps
);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_move_q;
    logic [1:0] r_board [8:0][8:0];
    logic [1:0] r_turn;
    logic [1:0] r_pass_cnt;
    logic       r_game_over;
    logic [7:0] r_move_count;
    logic       r_ack;
    logic       r_rej;
    logic       r_my_turn;

    coord_t     w_row;
    coord_t     w_col;
    logic       w_legal;
    logic       w_take_move;
    logic       w_take_pass;
    logic [1:0] w_turn_d;
    logic       w_go_d;
    logic       w_my_turn_d;

    assign w_row = r_move_q[7:4];
    assign w_col = r_move_q[3:0];

    assign w_take_move = (r_state == S_IDLE) && !r_game_over && move_ready;
    assign w_take_pass = (r_state == S_IDLE) && !r_game_over &&
                         !move_ready && pass_req;

    assign w_legal = (w_row <= 4'd8) && (w_col <= 4'd8) &&
                     (r_board[w_row][w_col] == EMPTY);

`ifdef GO_SINGLE_CAPTURE_EN
    logic [6:0] r_black_caps;
    logic [6:0] r_white_caps;
    coord_t     w_nb_row;
    coord_t     w_nb_col;
    logic       w_cap_state;
    logic       w_captured;

    // Neighbour under test for the current capture state
    always_comb begin
        w_nb_row    = w_row;
        w_nb_col    = w_col;
        w_cap_state = 1'b1;
        case (r_state)
            S_CAP_N: w_nb_row = w_row - 4'd1;
            S_CAP_S: w_nb_row = w_row + 4'd1;
            S_CAP_W: w_nb_col = w_col - 4'd1;
            S_CAP_E: w_nb_col = w_col + 4'd1;
            default: w_cap_state = 1'b0;
        endcase
    end

    go_capture_check u_cap (
        .board    (r_board),
        .nb_row   (w_nb_row),
        .nb_col   (w_nb_col),
        .mover    (r_turn),
        .captured (w_captured)
    );

    assign black_caps = r_black_caps;
    assign white_caps = r_white_caps;
`else
    assign black_caps = '0;
    assign white_caps = '0;
`endif

    // Next-state and registered-output targets
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_take_move) begin
                    w_next = S_CHECK;
                end else if (w_take_pass) begin
                    w_next = S_DONE;
                end
            end
            S_CHECK: w_next = w_legal ? S_PLACE : S_REJ;
`ifdef GO_SINGLE_CAPTURE_EN
            S_PLACE: w_next = S_CAP_N;
            S_CAP_N: w_next = S_CAP_S;
            S_CAP_S: w_next = S_CAP_W;
            S_CAP_W: w_next = S_CAP_E;
            S_CAP_E: w_next = S_DONE;
`else
            S_PLACE: w_next = S_DONE;
`endif
            S_DONE:  w_next = S_IDLE;
            S_REJ:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        w_turn_d    = (w_next == S_DONE) ? opponent(r_turn) : r_turn;
        w_go_d      = r_game_over || (w_take_pass && (r_pass_cnt == 2'd1));
        w_my_turn_d = (w_next == S_IDLE) && !w_go_d &&
                      ((LOCAL_COLOR == 2'b11) || (LOCAL_COLOR == w_turn_d));
    end

    // State, board contents, counters and output pulses
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_move_q <= '0;
            for (int r = 0; r < BOARD_N; r++) begin
                for (int c = 0; c < BOARD_N; c++) begin
                    r_board[r][c] <= EMPTY;
                end
            end
            r_turn       <= BLACK;
            r_pass_cnt   <= '0;
            r_game_over  <= 1'b0;
            r_move_count <= '0;
            r_ack        <= 1'b0;
            r_rej        <= 1'b0;
            r_my_turn    <= (LOCAL_COLOR == 2'b11) || (LOCAL_COLOR == BLACK);
`ifdef GO_SINGLE_CAPTURE_EN
            r_black_caps <= '0;
            r_white_caps <= '0;
`endif
        end else begin
            r_state     <= w_next;
            r_ack       <= (w_next == S_DONE);
            r_rej       <= (w_next == S_REJ);
            r_turn      <= w_turn_d;
            r_game_over <= w_go_d;
            r_my_turn   <= w_my_turn_d;
            if (w_take_move) begin
                r_move_q <= move_in;
            end
            if (w_take_pass && (r_pass_cnt != 2'd3)) begin
                r_pass_cnt <= r_pass_cnt + 2'd1;
            end
            if (r_state == S_PLACE) begin
                r_board[w_row][w_col] <= r_turn;
                r_pass_cnt            <= '0;
                if (r_move_count != 8'hFF) begin
                    r_move_count <= r_move_count + 8'd1;
                end
            end
`ifdef GO_SINGLE_CAPTURE_EN
            if (w_cap_state && w_captured) begin
                r_board[w_nb_row][w_nb_col] <= EMPTY;
                if (r_turn == BLACK) begin
                    if (r_black_caps != 7'h7F) begin
                        r_black_caps <= r_black_caps + 7'd1;
                    end
                end else begin
                    if (r_white_caps != 7'h7F) begin
                        r_white_caps <= r_white_caps + 7'd1;
                    end
                end
            end
`endif
        end
    end

    assign board      = r_board;
    assign turn       = r_turn;
    assign my_turn    = r_my_turn;
    assign move_ack   = r_ack;
    assign move_rej   = r_rej;
    assign game_over  = r_game_over;
    assign move_count = r_move_count;

endmodule

// File: tb/tb_go_move_commit.sv
// Testbench for go_move_commit: directed and random moves against a
// rule-level board model with cycle checks on ack/reject pulses.
module tb_go_move_commit;

    localparam logic [1:0] LC = 2'b11;
`ifdef GO_SINGLE_CAPTURE_EN
    localparam int ACK_CYC = 7;
    localparam int KILL_CYC = 4;
`else
    localparam int ACK_CYC = 3;
    localparam int KILL_CYC = 2;
`endif

    logic       clk_in = 1'b0;
    logic       reset_n = 1'b0;
    logic       move_ready = 1'b0;
    logic [7:0] move_in = '0;
    logic       pass_req = 1'b0;
    logic [1:0] board [8:0][8:0];
    logic [1:0] turn;
    logic       my_turn;
    logic       move_ack;
    logic       move_rej;
    logic       game_over;
    logic [7:0] move_count;
    logic [6:0] black_caps;
    logic [6:0] white_caps;

    int n_cmp = 0;
    int n_err = 0;

    int mb [9][9];
    int mturn, mpass, mgo, mcount, mbc, mwc;

    go_move_commit #(.LOCAL_COLOR(LC)) dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .move_ready (move_ready),
        .move_in    (move_in),
        .pass_req   (pass_req),
        .board      (board),
        .turn       (turn),
        .my_turn    (my_turn),
        .move_ack   (move_ack),
        .move_rej   (move_rej),
        .game_over  (game_over),
        .move_count (move_count),
        .black_caps (black_caps),
        .white_caps (white_caps)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                mb[r][c] = 0;
        mturn = 1; mpass = 0; mgo = 0; mcount = 0; mbc = 0; mwc = 0;
    endtask

    function automatic int exp_my_turn();
        return (mgo == 0 && (LC == 2'b11 || int'(LC) == mturn)) ? 1 : 0;
    endfunction

    function automatic bit inb(int r, int c);
        return r >= 0 && r < 9 && c >= 0 && c < 9;
    endfunction

    task automatic check_state(input string tag);
        logic [17:0] ro, re;
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 9; c++) begin
                ro[2*c +: 2] = board[r][c];
                re[2*c +: 2] = mb[r][c][1:0];
            end
            chk($sformatf("%s.row%0d", tag, r), 32'(ro), 32'(re));
        end
        chk({tag, ".turn"}, 32'(turn), 32'(mturn));
        chk({tag, ".my_turn"}, 32'(my_turn), 32'(exp_my_turn()));
        chk({tag, ".game_over"}, 32'(game_over), 32'(mgo));
        chk({tag, ".move_count"}, 32'(move_count), 32'(mcount));
        chk({tag, ".black_caps"}, 32'(black_caps), 32'(mbc));
        chk({tag, ".white_caps"}, 32'(white_caps), 32'(mwc));
    endtask

    // Apply one request to the model; returns expected ack/rej cycle (0 = none)
    task automatic model_op(input bit mv, input bit ps, input logic [7:0] m,
                            output int eack, output int erej);
        int r, c, opp;
        int dr [4] = '{-1, 1, 0, 0};
        int dc [4] = '{0, 0, -1, 1};
        eack = 0; erej = 0;
        if (mgo != 0) return;
        if (mv) begin
            r = int'(m[7:4]); c = int'(m[3:0]);
            if (r > 8 || c > 8 || mb[r][c] != 0) begin
                erej = 2;
                return;
            end
            mb[r][c] = mturn;
            mpass = 0;
            if (mcount < 255) mcount++;
`ifdef GO_SINGLE_CAPTURE_EN
            opp = 3 - mturn;
            for (int d = 0; d < 4; d++) begin
                int nr = r + dr[d];
                int nc = c + dc[d];
                if (inb(nr, nc) && mb[nr][nc] == opp) begin
                    bit dead = 1;
                    for (int e = 0; e < 4; e++) begin
                        int ar = nr + dr[e];
                        int ac = nc + dc[e];
                        if (inb(ar, ac) && mb[ar][ac] != mturn) dead = 0;
                    end
                    if (dead) begin
                        mb[nr][nc] = 0;
                        if (mturn == 1) mbc = (mbc < 127) ? mbc + 1 : 127;
                        else mwc = (mwc < 127) ? mwc + 1 : 127;
                    end
                end
            end
`else
            opp = 0;
`endif
            eack = ACK_CYC;
            mturn = 3 - mturn;
            if (opp < 0) eack = 0;
        end else if (ps) begin
            if (mpass == 1) mgo = 1;
            mpass++;
            eack = 1;
            mturn = 3 - mturn;
        end
    endtask

    task automatic do_op(input string tag, input bit mv, input bit ps,
                         input logic [7:0] m);
        int eack, erej, ack_at, rej_at, npulse, mt1;
        model_op(mv, ps, m, eack, erej);
        @(negedge clk_in);
        move_ready = mv; pass_req = ps; move_in = m;
        @(posedge clk_in);
        @(negedge clk_in);
        move_ready = 1'b0; pass_req = 1'b0;
        move_in = 8'($urandom);
        ack_at = 0; rej_at = 0; npulse = 0; mt1 = int'(my_turn);
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) @(negedge clk_in);
            if (move_ack) begin npulse++; if (ack_at == 0) ack_at = k; end
            if (move_rej) begin npulse++; if (rej_at == 0) rej_at = k; end
        end
        chk({tag, ".ack_cycle"}, 32'(ack_at), 32'(eack));
        chk({tag, ".rej_cycle"}, 32'(rej_at), 32'(erej));
        chk({tag, ".pulses"}, 32'(npulse), 32'((eack | erej) != 0));
        chk({tag, ".my_turn_c1"}, 32'(mt1),
            32'(((eack | erej) != 0) ? 0 : exp_my_turn()));
        check_state(tag);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        move_ready = 1'b0; pass_req = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk_in);
        reset_n = 1'b1;
        model_init();
    endtask

    initial begin
        int seen;
        model_init();
        do_reset();
        check_state("reset");
        chk("reset.ack", 32'(move_ack), 32'd0);
        chk("reset.rej", 32'(move_rej), 32'd0);

        do_op("m44", 1'b1, 1'b0, 8'h44);
        chk("m44.cell", 32'(board[4][4]), 32'd1);
        chk("m44.turn", 32'(turn), 32'd2);
        chk("m44.count", 32'(move_count), 32'd1);
        do_op("m44_again", 1'b1, 1'b0, 8'h44);
        chk("m44_again.turn", 32'(turn), 32'd2);
        do_op("m49", 1'b1, 1'b0, 8'h49);
        do_op("m90", 1'b1, 1'b0, 8'h90);

        do_reset();
        do_op("capB11", 1'b1, 1'b0, 8'h11);
        do_op("capW00", 1'b1, 1'b0, 8'h00);
        do_op("capB01", 1'b1, 1'b0, 8'h01);
        do_op("capW88", 1'b1, 1'b0, 8'h88);
        do_op("capB10", 1'b1, 1'b0, 8'h10);
`ifdef GO_SINGLE_CAPTURE_EN
        chk("cap.corner", 32'(board[0][0]), 32'd0);
        chk("cap.bcaps", 32'(black_caps), 32'd1);
`else
        chk("cap.corner", 32'(board[0][0]), 32'd2);
        chk("cap.bcaps", 32'(black_caps), 32'd0);
`endif

        do_reset();
        do_op("pmp.p1", 1'b0, 1'b1, 8'h00);
        do_op("pmp.m", 1'b1, 1'b0, 8'h33);
        do_op("pmp.p2", 1'b0, 1'b1, 8'h00);
        chk("pmp.go", 32'(game_over), 32'd0);
        do_op("both", 1'b1, 1'b1, 8'h34);
        do_op("pp.p1", 1'b0, 1'b1, 8'h00);
        do_op("pp.p2", 1'b0, 1'b1, 8'h00);
        chk("pp.go", 32'(game_over), 32'd1);
        chk("pp.my_turn", 32'(my_turn), 32'd0);
        do_op("over.m22", 1'b1, 1'b0, 8'h22);
        do_op("over.pass", 1'b0, 1'b1, 8'h00);

        do_reset();
        @(negedge clk_in);
        move_ready = 1'b1; move_in = 8'h55;
        @(posedge clk_in);
        @(negedge clk_in);
        move_ready = 1'b0;
        repeat (KILL_CYC - 1) @(negedge clk_in);
        #2 reset_n = 1'b0;
        #1;
        model_init();
        check_state("kill");
        chk("kill.ack", 32'(move_ack), 32'd0);
        chk("kill.rej", 32'(move_rej), 32'd0);
        seen = 0;
        repeat (3) begin @(negedge clk_in); seen += int'(move_ack); end
        reset_n = 1'b1;
        repeat (10) begin
            @(negedge clk_in);
            seen += int'(move_ack) + int'(move_rej);
        end
        chk("kill.no_ack", 32'(seen), 32'd0);
        check_state("kill.after");

        for (int i = 0; i < 150; i++) begin
            int kind;
            logic [7:0] m;
            kind = $urandom_range(0, 19);
            m = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if (kind == 0) do_op("rnd.pass", 1'b0, 1'b1, m);
            else if (kind == 1) do_op("rnd.both", 1'b1, 1'b1, m);
            else do_op("rnd.move", 1'b1, 1'b0, m);
            if (mgo != 0) begin
                do_op("rnd.ignored", 1'b1, 1'b0, m);
                do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
